// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing, sync windows and the shared
// 10-bit screen coordinate type used by the object generators.
package vga_timing_pkg;
    typedef logic [9:0] coord_t;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam coord_t DEF_HS_START = coord_t'(DEF_H_VISIBLE + DEF_H_FRONT);
    localparam coord_t DEF_HS_END   = coord_t'(DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1);
    localparam coord_t DEF_VS_START = coord_t'(DEF_V_VISIBLE + DEF_V_FRONT);
    localparam coord_t DEF_VS_END   = coord_t'(DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC - 1);

    function automatic logic in_span(input coord_t c, input coord_t lo, input coord_t hi);
        return c >= lo && c <= hi;
    endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides the board clock down to a registered one-clk pixel strobe.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic pixel_tick
);
    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    logic [3:0] div_q, div_d;
    logic       tick_q, tick_d;

    always_comb begin
        tick_d = div_q == DIV_MAX;
        div_d  = tick_d ? 4'd0 : div_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q  <= 4'd0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pixel_tick = tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters with sync/blank/frame decode registered alongside
// the counts, so every output is coherent with HCount/VCount on the same cycle.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       HSync,
    output logic       VSync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be in 1..16");
    end

    coord_t hcount_q, hcount_d, vcount_q, vcount_d;
    logic   hsync_q, hsync_d, vsync_q, vsync_d;
    logic   video_on_q, video_on_d, frame_start_q, frame_start_d;
    logic   tick, h_wrap, v_wrap;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .pixel_tick(tick)
    );

    // Decode only on ticks so the post-reset blank of (0,0) holds until the first advance.
    always_comb begin
        h_wrap        = hcount_q == H_LAST;
        v_wrap        = vcount_q == V_LAST;
        hcount_d      = tick ? (h_wrap ? '0 : hcount_q + 10'd1) : hcount_q;
        vcount_d      = (tick && h_wrap) ? (v_wrap ? '0 : vcount_q + 10'd1) : vcount_q;
        hsync_d       = tick ? !in_span(hcount_d, HS_START, HS_END) : hsync_q;
        vsync_d       = tick ? !in_span(vcount_d, VS_START, VS_END) : vsync_q;
        video_on_d    = tick ? (hcount_d < H_VIS && vcount_d < V_VIS) : video_on_q;
        frame_start_d = tick && h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HCount      = hcount_q;
    assign VCount      = vcount_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_tick  = tick;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks plus a closed-form per-clock reference for three
// configurations (default, tiny DIV=1 raster, tiny line with full-height frame).
module tb_vga_sync_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;
    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_hs, a_vs, a_von, a_pt, a_fs;
    logic b_hs, b_vs, b_von, b_pt, b_fs;
    logic c_hs, c_vs, c_von, c_pt, c_fs;
    logic [24:0] a_out, b_out, c_out;
    assign a_out = {a_h, a_v, a_hs, a_vs, a_von, a_pt, a_fs};
    assign b_out = {b_h, b_v, b_hs, b_vs, b_von, b_pt, b_fs};
    assign c_out = {c_h, c_v, c_hs, c_vs, c_von, c_pt, c_fs};

    vga_sync_gen u_a (
        .clk(clk), .reset_n(rst_a_n), .HCount(a_h), .VCount(a_v), .HSync(a_hs),
        .VSync(a_vs), .video_on(a_von), .pixel_tick(a_pt), .frame_start(a_fs)
    );
    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_b (
        .clk(clk), .reset_n(rst_b_n), .HCount(b_h), .VCount(b_v), .HSync(b_hs),
        .VSync(b_vs), .video_on(b_von), .pixel_tick(b_pt), .frame_start(b_fs)
    );
    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)
    ) u_c (
        .clk(clk), .reset_n(rst_c_n), .HCount(c_h), .VCount(c_v), .HSync(c_hs),
        .VSync(c_vs), .video_on(c_von), .pixel_tick(c_pt), .frame_start(c_fs)
    );

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // k = clk edges since reset release (0 = in reset); after edge k the counts have
    // advanced floor((k-1)/div) times and the strobe is high when k is a multiple of div.
    function automatic logic [24:0] model(input int k, input int div, input int hv, input int hf,
                                          input int hw, input int hb, input int vv, input int vf,
                                          input int vw, input int vb);
        int ht, vt, p, h, v;
        logic hs, vs, von, pt, fs;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        p  = k > 0 ? (k - 1) / div : 0;
        h  = p % ht;
        v  = (p / ht) % vt;
        pt = k > 0 && k % div == 0;
        if (p == 0) begin
            hs = 1'b1; vs = 1'b1; von = 1'b0; fs = 1'b0;
        end else begin
            hs  = !(h >= hv + hf && h < hv + hf + hw);
            vs  = !(v >= vv + vf && v < vv + vf + vw);
            von = h < hv && v < vv;
            fs  = h == 0 && v == 0 && (k - 1) % div == 0;
        end
        return {10'(h), 10'(v), hs, vs, von, pt, fs};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hs_fall = -1, hs_rise = -1, von_fall = -1, line0 = -1, line1 = -1;
    int fs0 = -1, fs1 = -1, w0 = -1, w1 = -1, vs_low = 0;
    logic prev_hs, prev_von;
    logic [9:0] prev_h;

    initial begin
        repeat (3) step();
        check("rst_a", a_out, {10'd0, 10'd0, 5'b11000});
        check("rst_b", b_out, {10'd0, 10'd0, 5'b11000});
        @(negedge clk);
        rst_a_n = 1'b1;
        prev_hs = 1'b1;
        prev_von = 1'b0;
        for (int k = 1; k <= 3801; k++) begin
            step();
            check("sb_a", a_out, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            if (k == 1) check("a_no_tick_k1", a_pt, 1'b0);
            if (k == 2) check("a_first_tick", a_pt, 1'b1);
            if (k == 3) check("a_after_tick", {a_h, a_von}, {10'd1, 1'b1});
            if (prev_hs && !a_hs && hs_fall < 0) begin
                hs_fall = k;
                check("hs_fall_h", a_h, 10'd656);
            end
            if (!prev_hs && a_hs && hs_fall >= 0 && hs_rise < 0) begin
                hs_rise = k;
                check("hs_rise_h", a_h, 10'd752);
            end
            if (prev_von && !a_von && von_fall < 0) begin
                von_fall = k;
                check("von_fall_h", a_h, 10'd640);
            end
            if (a_h == 0 && a_v == 1 && line0 < 0) line0 = k;
            if (a_h == 0 && a_v == 2 && line1 < 0) line1 = k;
            prev_hs = a_hs;
            prev_von = a_von;
        end
        check("hs_width", hs_rise - hs_fall, 192);
        check("line_period", line1 - line0, 1600);
        check("a_mid_pos", {a_h, a_v}, {10'd300, 10'd2});
        rst_a_n = 1'b0;
        step();
        check("a_mid_rst", a_out, {10'd0, 10'd0, 5'b11000});
        step();
        check("a_rst_hold", a_out, {10'd0, 10'd0, 5'b11000});
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("a_restart", a_out, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            if (k == 3) check("a_restart_h1", a_h, 10'd1);
        end

        @(negedge clk);
        rst_b_n = 1'b1;
        prev_h = 10'd0;
        for (int k = 1; k <= 300; k++) begin
            step();
            check("sb_b", b_out, model(k, 1, 8, 2, 2, 2, 4, 1, 1, 1));
            if (k == 1) check("b_tick_k1", b_pt, 1'b1);
            if (b_h == 10 || b_h == 11) check("b_hs_low", b_hs, 1'b0);
            if (b_v == 5) check("b_vs_low", b_vs, 1'b0);
            if (b_fs && fs0 < 0) fs0 = k;
            else if (b_fs && fs1 < 0) fs1 = k;
            if (prev_h == 13 && b_h == 0) begin
                if (w0 < 0) w0 = k;
                else if (w1 < 0) w1 = k;
            end
            prev_h = b_h;
        end
        check("b_first_fs", fs0, 99);
        check("b_frame", fs1 - fs0, 98);
        check("b_hwrap", w1 - w0, 14);

        @(negedge clk);
        rst_c_n = 1'b1;
        for (int k = 1; k <= 7360; k++) begin
            step();
            check("sb_c", c_out, model(k, 1, 8, 2, 2, 2, 480, 10, 2, 33));
            if (!c_vs) vs_low++;
            if (k == 7350) check("c_pre_wrap", {c_h, c_v, c_fs}, {10'd13, 10'd524, 1'b0});
            if (k == 7351) check("c_wrap", {c_h, c_v, c_fs, c_von}, {10'd0, 10'd0, 2'b11});
            if (k == 7352) check("c_fs_drop", {c_h, c_fs}, {10'd1, 1'b0});
        end
        check("c_vs_low_clks", vs_low, 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
